moving_average2_decoder: RTL and testbench

//  Inverse of the MovingAverage2 moving-sum stage. Takes the WINDOW-sample moving-sum stream
//  s[n] = s[n-1] + x[n] - x[n-WINDOW] and rebuilds the original samples as
//  x[n] = s[n] - s[n-1] + x[n-WINDOW], all in wrapping WIDTH-bit arithmetic.

---
 rtl/mavg_pkg.sv | 17 +
 rtl/mavg_history_ring.sv | 55 +++++
 rtl/moving_average2_decoder.sv | 94 +++++++++
 tb/tb_moving_average2_decoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mavg_pkg.sv
// Shared moving-average definitions used by both the encoder and this decoder.
// Holds the default sample width and window depth, the sample type, and the
// history-pointer increment helper.
package mavg_pkg;

  localparam int unsigned MAVG_WIDTH  = 8;
  localparam int unsigned MAVG_WINDOW = 16;

  typedef logic signed [MAVG_WIDTH-1:0] sample_t;

  // Next history slot, wrapping window-1 back to 0.
  function automatic int unsigned mavg_ptr_next(input int unsigned ptr,
                                                input int unsigned window);
    return (ptr == window - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mavg_history_ring.sv
// Circular buffer holding the last WINDOW reconstructed samples.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   clr         synchronous clear of all entries and the pointer
//   we          write wdata at the current slot and advance the pointer
//   wdata       sample to store
//   rd_data_c   combinational read of the current (oldest) slot
module mavg_history_ring
  import mavg_pkg::*;
#(
  parameter int unsigned WIDTH  = MAVG_WIDTH,
  parameter int unsigned WINDOW = MAVG_WINDOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rd_data_c
);

  localparam int unsigned PTR_W = $clog2(WINDOW);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [WINDOW];
  logic [WIDTH-1:0] mem_d [WINDOW];

  // The slot about to be overwritten is the oldest sample, x[n-WINDOW].
  assign rd_data_c = mem_q[ptr_q];

  // Next-state for the buffer and pointer; clear wins over a write.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < int'(WINDOW); i++) mem_d[i] = mem_q[i];
    if (clr) begin
      ptr_d = '0;
      for (int i = 0; i < int'(WINDOW); i++) mem_d[i] = '0;
    end else if (we) begin
      mem_d[ptr_q] = wdata;
      ptr_d        = PTR_W'(mavg_ptr_next(32'(ptr_q), WINDOW));
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < int'(WINDOW); i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < int'(WINDOW); i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/moving_average2_decoder.sv
// Inverse of the MovingAverage2 moving-sum stage: rebuilds samples as
// x[n] = s[n] - s[n-1] + x[n-WINDOW] in wrapping WIDTH-bit arithmetic.
// Optional macro MAVG_DEC_CLR_EN adds the clr resync input.
// Ports:
//   system1000       clock, rising edge
//   system1000_rstn  async active-low reset
//   in_valid/in_sum  moving-sum input, in_ready is combinational backpressure
//   out_valid/out_sample/out_ready  reconstructed sample output (1-cycle latency)
//   clr              (MAVG_DEC_CLR_EN) synchronous clear of decoder state
module moving_average2_decoder
  import mavg_pkg::*;
#(
  parameter int unsigned WIDTH  = MAVG_WIDTH,
  parameter int unsigned WINDOW = MAVG_WINDOW
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sum,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sample,
  input  logic             out_ready
`ifdef MAVG_DEC_CLR_EN
  ,
  input  logic             clr
`endif
);

  logic             clr_c;
  logic             in_fire_c;
  logic [WIDTH-1:0] hist_rd_c;
  logic [WIDTH-1:0] x_c;
  logic [WIDTH-1:0] prev_sum_q, prev_sum_d;
  logic [WIDTH-1:0] out_sample_q, out_sample_d;
  logic             out_valid_q, out_valid_d;

`ifdef MAVG_DEC_CLR_EN
  assign clr_c = clr;
`else
  assign clr_c = 1'b0;
`endif

  // Oldest sample history; written with each reconstructed sample.
  mavg_history_ring #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW)
  ) u_hist (
    .clk       (system1000),
    .rst_n     (system1000_rstn),
    .clr       (clr_c),
    .we        (in_fire_c),
    .wdata     (x_c),
    .rd_data_c (hist_rd_c)
  );

  // Handshake, reconstruction and output-register next state.
  // clr forces in_ready low, so a coincident input is never accepted.
  always_comb begin
    in_ready     = ~clr_c & (~out_valid_q | out_ready);
    in_fire_c    = in_valid & in_ready;
    x_c          = in_sum - prev_sum_q + hist_rd_c;
    prev_sum_d   = prev_sum_q;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q;
    if (clr_c) begin
      prev_sum_d  = '0;
      out_valid_d = 1'b0;
    end else if (in_fire_c) begin
      prev_sum_d   = in_sum;
      out_sample_d = x_c;
      out_valid_d  = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      prev_sum_q   <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      prev_sum_q   <= prev_sum_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

endmodule

// File: tb/tb_moving_average2_decoder.sv
// Self-checking bench: a behavioural moving-sum encoder feeds the decoder and
// the original samples are queued as expected outputs for a separate monitor.
module tb_moving_average2_decoder;
  import mavg_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic [7:0] in_sum;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_sample;
  logic       out_ready;
`ifdef MAVG_DEC_CLR_EN
  logic       clr;
`endif

  int errors = 0;
  int checks = 0;

  sample_t    sb[$];
  logic [7:0] ehist [16];
  logic [7:0] esum;
  logic [3:0] eptr;

  logic       hold_v;
  logic [7:0] hold_s;

  moving_average2_decoder dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .in_valid        (in_valid),
    .in_sum          (in_sum),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_sample      (out_sample),
    .out_ready       (out_ready)
`ifdef MAVG_DEC_CLR_EN
    ,
    .clr             (clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic enc_reset();
    for (int i = 0; i < 16; i++) ehist[i] = 8'd0;
    esum = 8'd0;
    eptr = 4'd0;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Present one encoded sample until it is accepted.
  task automatic drive_sample(input logic [7:0] x, input int vpct, input int rpct,
                              input bit b2b, input int idx);
    bit done  = 1'b0;
    int guard = 0;
    while (!done) begin
      @(posedge clk); #1;
      in_valid  = (int'($urandom_range(99)) < vpct);
      out_ready = (int'($urandom_range(99)) < rpct);
      in_sum    = esum + x - ehist[eptr];
      @(negedge clk);
      if (b2b) begin
        check("b2b_in_ready", 8'(in_ready), 8'd1);
        if (idx > 0) check("b2b_out_valid", 8'(out_valid), 8'd1);
      end
      if (in_valid && in_ready) begin
        sb.push_back(sample_t'(x));
        ehist[eptr] = x;
        esum        = in_sum;
        eptr        = eptr + 4'd1;
        done        = 1'b1;
      end
      guard++;
      if (!done && guard > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        done = 1'b1;
      end
    end
  endtask

  // Stop input and wait for every queued sample to leave the decoder.
  task automatic drain();
    int n = 0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("drain_empty", 8'(sb.size()), 8'd0);
  endtask

  // Monitor: compare every transferred output and check stall stability.
  always @(negedge clk) begin
    if (rstn) begin
      if (hold_v) begin
        check("hold_valid", 8'(out_valid), 8'd1);
        check("hold_sample", out_sample, hold_s);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected no output", out_sample);
        end else begin
          check("out_sample", out_sample, 8'(sb.pop_front()));
        end
      end
      hold_v = out_valid && !out_ready;
      hold_s = out_sample;
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    hold_v    = 1'b0;
    hold_s    = 8'd0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_sum    = 8'd0;
    out_ready = 1'b0;
`ifdef MAVG_DEC_CLR_EN
    clr       = 1'b0;
`endif
    enc_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_sample", out_sample, 8'd0);
    check("rst_in_ready", 8'(in_ready), 8'd1);
    rstn = 1'b1;

    // Impulse: 5 then twenty zeros.
    drive_sample(8'd5, 100, 100, 1'b0, 0);
    for (int i = 0; i < 20; i++) drive_sample(8'd0, 100, 100, 1'b0, 0);
    drain();

    // Constant 127: sums wrap through 254 (-2) and beyond.
    for (int i = 0; i < 40; i++) drive_sample(8'd127, 100, 100, 1'b0, 0);
    drain();

    // Random valid/ready backpressure with random data.
    for (int i = 0; i < 1000; i++) drive_sample(8'($urandom), 60, 55, 1'b0, 0);
    drain();

    // Back-to-back full throughput.
    for (int i = 0; i < 30; i++) drive_sample(8'(i * 7 - 50), 100, 100, 1'b1, i);
    drain();

    // Reset mid-stream after ramp sample 37.
    for (int i = 1; i <= 37; i++) drive_sample(8'(i), 100, 100, 1'b0, 0);
    @(posedge clk); #1;
    rstn     = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 8'(out_valid), 8'd0);
    sb.delete();
    enc_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 1; i <= 40; i++) drive_sample(8'(i), 100, 100, 1'b0, 0);
    drain();

`ifdef MAVG_DEC_CLR_EN
    // clr with a valid input: the sample is dropped and state resyncs.
    for (int i = 0; i < 9; i++) drive_sample(8'(i + 3), 100, 100, 1'b0, 0);
    drain();
    @(posedge clk); #1;
    clr       = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 8'd99;
    out_ready = 1'b1;
    #1;
    check("clr_in_ready", 8'(in_ready), 8'd0);
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_out_valid", 8'(out_valid), 8'd0);
    enc_reset();
    for (int i = 0; i < 25; i++) drive_sample(8'(i * 11), 100, 100, 1'b0, 0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
